// File: rtl/dct_2d_sequencer.sv
// dct_2d_sequencer: runs a 1-D transform engine over the N rows, then the
// N columns, of an NxN block and owns the transpose and scratch memory.
module dct_2d_sequencer #(
  parameter int LOG2_N     = 3,
  parameter int IN_WIDTH   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int SCRATCH_AW = 5
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  rows_only,
  output logic                  busy,
  output logic                  done,
  output logic [2*LOG2_N-1:0]   src_addr,
  input  logic [IN_WIDTH-1:0]   src_data,
  output logic [2*LOG2_N-1:0]   result_addr,
  output logic                  result_wren,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  eng_nreset,
  input  logic [LOG2_N-1:0]     eng_fetch_addr,
  output logic [DATA_WIDTH-1:0] eng_src_data,
  input  logic                  eng_read_scratch,
  input  logic [SCRATCH_AW-1:0] eng_scratch_raddr,
  output logic [DATA_WIDTH-1:0] eng_scratch_rdata,
  input  logic [LOG2_N-1:0]     eng_result_addr,
  input  logic                  eng_result_wren,
  input  logic [DATA_WIDTH-1:0] eng_result_data,
  input  logic [SCRATCH_AW-1:0] eng_scratch_waddr,
  input  logic                  eng_scratch_wren,
  input  logic [DATA_WIDTH-1:0] eng_scratch_wdata,
  input  logic                  eng_finished
);

  localparam int AW    = 2 * LOG2_N;
  localparam int NN    = 1 << AW;
  localparam int DEPTH = NN + (1 << SCRATCH_AW);
  localparam int MAW   = $clog2(DEPTH);

  localparam logic [LOG2_N:0] LINE_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE_RST,
    S_LINE_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [LOG2_N:0] line_q, line_d;
  logic rows_only_q, rows_only_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic eng_nreset_q, eng_nreset_d;
  logic fin_q;
  logic rd_scr_q;

  logic col_pass;
  logic last_line;
  logic fin_rise;
  logic running;
  logic [LOG2_N-1:0] lnum;

  logic [AW-1:0] fetch_row_idx;
  logic [AW-1:0] fetch_col_idx;
  logic [AW-1:0] res_row_idx;
  logic [AW-1:0] res_col_idx;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [MAW-1:0] raddr;
  logic [MAW-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic we;
  logic scr_we;
  logic line_we;

  // line_q MSB selects the pass; low bits are the line number
  assign col_pass = line_q[LOG2_N];
  assign lnum     = line_q[LOG2_N-1:0];
  assign running  = (state_q == S_LINE_RUN);
  assign fin_rise = eng_finished & ~fin_q;

  assign last_line = (&lnum) & (rows_only_q | col_pass);

  assign fetch_row_idx = {lnum, eng_fetch_addr};
  assign fetch_col_idx = {eng_fetch_addr, lnum};
  assign res_row_idx   = {lnum, eng_result_addr};
  assign res_col_idx   = {eng_result_addr, lnum};

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    rows_only_d = rows_only_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LINE_RST;
          line_d      = '0;
          rows_only_d = rows_only;
        end
      end
      S_LINE_RST: state_d = S_LINE_RUN;
      S_LINE_RUN: begin
        if (fin_rise) begin
          if (last_line) begin
            state_d = S_DONE;
          end else begin
            line_d  = line_q + LINE_ONE;
            state_d = S_LINE_RST;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    eng_nreset_d = (state_d == S_LINE_RUN);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      rows_only_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      eng_nreset_q <= 1'b0;
      fin_q        <= 1'b0;
      rd_scr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      rows_only_q  <= rows_only_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      eng_nreset_q <= eng_nreset_d;
      fin_q        <= eng_finished;
      rd_scr_q     <= eng_read_scratch;
    end
  end

  // scratch writes win over a colliding line-region write
  assign scr_we  = running & eng_scratch_wren;
  assign line_we = running & eng_result_wren
                 & ~col_pass & ~rows_only_q;

  always_comb begin
    raddr = MAW'(fetch_col_idx);
    if (eng_read_scratch) begin
      raddr = MAW'(NN) + MAW'(eng_scratch_raddr);
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (scr_we) begin
      we    = 1'b1;
      waddr = MAW'(NN) + MAW'(eng_scratch_waddr);
      wdata = eng_scratch_wdata;
    end else if (line_we) begin
      we    = 1'b1;
      waddr = MAW'(res_row_idx);
      wdata = eng_result_data;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign src_addr = busy_q ? fetch_row_idx : '0;

  assign eng_src_data = col_pass
                      ? rdata_q
                      : DATA_WIDTH'($signed(src_data));

  assign eng_scratch_rdata = rd_scr_q ? rdata_q : '0;

  assign result_wren = running & eng_result_wren
                     & (col_pass | rows_only_q);

  assign result_addr = !result_wren ? '0
                     : col_pass ? res_col_idx
                     : res_row_idx;

  assign result_data = eng_result_data;
  assign busy        = busy_q;
  assign done        = done_q;
  assign eng_nreset  = eng_nreset_q;

endmodule

// File: tb/tb_dct_2d_sequencer.sv
// tb_dct_2d_sequencer: stub engines on an 8x8 and a 4x4 sequencer,
// expected writes queued at stimulus time and popped by a monitor.
module tb_dct_2d_sequencer;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // {instance, address, data}
  logic [31:0] exp_q [$];

  logic start_v [2] = '{1'b0, 1'b0};
  logic rows_v  [2] = '{1'b0, 1'b0};
  logic hold_v  [2] = '{1'b0, 1'b0};
  logic f80 = 1'b0;

  logic busy_v [2];
  logic done_v [2];
  logic enr_v  [2];
  logic [15:0] esd_v [2];
  int done_cnt [2] = '{0, 0};
  int wr_cnt   [2] = '{0, 0};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LG = (g == 0) ? 3 : 2;
    localparam int N  = 1 << LG;

    logic busy, done, eng_nreset, result_wren;
    logic [2*LG-1:0] src_addr, result_addr;
    logic [7:0] src_data;
    logic [15:0] result_data, eng_src_data, eng_scratch_rdata;
    logic [LG-1:0] eng_fetch_addr, eng_result_addr;
    logic eng_read_scratch, eng_result_wren;
    logic eng_scratch_wren, eng_finished;
    logic [4:0] eng_scratch_raddr, eng_scratch_waddr;
    logic [15:0] eng_result_data, eng_scratch_wdata;

    int ph = 0;
    int cnt = 0;
    int sub = 0;
    logic fin = 1'b0;
    logic [15:0] lbuf [N];

    assign src_data = f80 ? 8'h80 : 8'(src_addr) - 8'd64;

    dct_2d_sequencer #(
      .LOG2_N(LG), .IN_WIDTH(8),
      .DATA_WIDTH(16), .SCRATCH_AW(5)
    ) u_dut (
      .clock(clock),
      .nreset(nreset),
      .start(start_v[g]),
      .rows_only(rows_v[g]),
      .busy(busy),
      .done(done),
      .src_addr(src_addr),
      .src_data(src_data),
      .result_addr(result_addr),
      .result_wren(result_wren),
      .result_data(result_data),
      .eng_nreset(eng_nreset),
      .eng_fetch_addr(eng_fetch_addr),
      .eng_src_data(eng_src_data),
      .eng_read_scratch(eng_read_scratch),
      .eng_scratch_raddr(eng_scratch_raddr),
      .eng_scratch_rdata(eng_scratch_rdata),
      .eng_result_addr(eng_result_addr),
      .eng_result_wren(eng_result_wren),
      .eng_result_data(eng_result_data),
      .eng_scratch_waddr(eng_scratch_waddr),
      .eng_scratch_wren(eng_scratch_wren),
      .eng_scratch_wdata(eng_scratch_wdata),
      .eng_finished(eng_finished)
    );

    assign busy_v[g] = busy;
    assign done_v[g] = done;
    assign enr_v[g]  = eng_nreset;
    assign esd_v[g]  = eng_src_data;

    assign eng_fetch_addr    = LG'(cnt);
    assign eng_result_addr   = LG'(cnt);
    assign eng_result_wren   = (ph == 1);
    assign eng_result_data   = lbuf[cnt] + 16'd1;
    assign eng_scratch_wren  = (ph == 2);
    assign eng_scratch_waddr = 5'd5;
    assign eng_scratch_wdata = 16'h1234;
    assign eng_read_scratch  = (ph == 3);
    assign eng_scratch_raddr = 5'd5;
    assign eng_finished      = fin;

    // stub engine: fetch (two cycles per sample), write +1, scratch, finish
    always @(negedge clock) begin
      if (!eng_nreset) begin
        ph  <= 0;
        cnt <= 0;
        sub <= 0;
        if (!hold_v[g]) fin <= 1'b0;
      end else if (ph == 0 && fin) begin
        fin <= 1'b0;
      end else begin
        case (ph)
          0: begin
            if (sub == 0) begin
              sub <= 1;
            end else begin
              lbuf[cnt] <= eng_src_data;
              sub <= 0;
              if (cnt == N - 1) begin
                cnt <= 0;
                ph  <= 1;
              end else begin
                cnt <= cnt + 1;
              end
            end
          end
          1: begin
            if (cnt == N - 1) begin
              cnt <= 0;
              ph  <= 2;
            end else begin
              cnt <= cnt + 1;
            end
          end
          2: ph <= 3;
          3: begin
            chk("scratch_rd", 32'(eng_scratch_rdata), 32'h1234);
            ph <= 4;
          end
          4: fin <= 1'b1;
          default: ph <= 0;
        endcase
      end
    end

    always @(negedge clock) begin
      if (done) done_cnt[g] <= done_cnt[g] + 1;
      if (result_wren) begin
        wr_cnt[g] <= wr_cnt[g] + 1;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_write: inst %0d addr %0d data %h, none expected",
                   g, result_addr, result_data);
        end else begin
          chk("result_write",
              {8'(g), 8'(result_addr), result_data},
              exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_block(input int g, input int lg,
                            input bit ro, input bit c80);
    int n;
    n = 1 << lg;
    for (int l = 0; l < n; l++) begin
      for (int i = 0; i < n; i++) begin
        int a;
        logic [15:0] d;
        a = ro ? (l * n + i) : (i * n + l);
        if (c80) d = ro ? 16'hFF81 : 16'hFF82;
        else d = 16'(a) - (ro ? 16'd63 : 16'd62);
        exp_q.push_back({8'(g), 8'(a), d});
      end
    end
  endtask

  task automatic run_block(input int g, input bit ro, input bit spam);
    int d0;
    int cyc;
    d0 = done_cnt[g];
    @(negedge clock);
    start_v[g] = 1'b1;
    rows_v[g]  = ro;
    @(negedge clock);
    start_v[g] = 1'b0;
    rows_v[g]  = ~ro;
    chk("busy_rise", 32'(busy_v[g]), 32'd1);
    chk("eng_rst_line", 32'(enr_v[g]), 32'd0);
    @(negedge clock);
    chk("eng_run", 32'(enr_v[g]), 32'd1);
    chk("eng_src_sext", 32'(esd_v[g]),
        f80 ? 32'hFF80 : 32'hFFC0);
    cyc = 0;
    while (!done_v[g] && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      start_v[g] = spam && (cyc % 41 == 7);
    end
    chk("done_seen", 32'(done_v[g]), 32'd1);
    chk("busy_in_done", 32'(busy_v[g]), 32'd1);
    start_v[g] = spam;
    @(negedge clock);
    start_v[g] = 1'b0;
    chk("busy_fall", 32'(busy_v[g]), 32'd0);
    chk("done_pulse", 32'(done_v[g]), 32'd0);
    repeat (12) @(negedge clock);
    chk("done_count", 32'(done_cnt[g] - d0), 32'd1);
    chk("busy_idle", 32'(busy_v[g]), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int d0;
    int cyc;

    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(gi[0].busy), 32'd0);
    chk("rst_done", 32'(gi[0].done), 32'd0);
    chk("rst_eng_nreset", 32'(gi[0].eng_nreset), 32'd0);
    chk("rst_wren", 32'(gi[0].result_wren), 32'd0);
    chk("rst_raddr", 32'(gi[0].result_addr), 32'd0);
    chk("rst_src_addr", 32'(gi[0].src_addr), 32'd0);
    chk("rst_busy_4x4", 32'(gi[1].busy), 32'd0);
    nreset = 1'b1;
    repeat (2) @(negedge clock);

    push_block(0, 3, 1'b1, 1'b0);
    run_block(0, 1'b1, 1'b0);

    push_block(0, 3, 1'b0, 1'b0);
    run_block(0, 1'b0, 1'b0);

    f80 = 1'b1;
    push_block(0, 3, 1'b1, 1'b1);
    run_block(0, 1'b1, 1'b1);
    f80 = 1'b0;

    base = wr_cnt[0];
    d0   = done_cnt[0];
    push_block(0, 3, 1'b0, 1'b0);
    @(negedge clock);
    start_v[0] = 1'b1;
    rows_v[0]  = 1'b0;
    @(negedge clock);
    start_v[0] = 1'b0;
    cyc = 0;
    while (wr_cnt[0] < base + 26 && cyc < 4000) begin
      @(negedge clock);
      cyc++;
    end
    chk("abort_reached", 32'(wr_cnt[0] - base >= 26), 32'd1);
    #2 nreset = 1'b0;
    #1;
    chk("abort_busy", 32'(gi[0].busy), 32'd0);
    chk("abort_done", 32'(gi[0].done), 32'd0);
    chk("abort_wren", 32'(gi[0].result_wren), 32'd0);
    chk("abort_eng_nreset", 32'(gi[0].eng_nreset), 32'd0);
    exp_q.delete();
    base = wr_cnt[0];
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;
    repeat (30) @(negedge clock);
    chk("abort_no_writes", 32'(wr_cnt[0] - base), 32'd0);
    chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
    chk("abort_idle", 32'(gi[0].busy), 32'd0);

    push_block(0, 3, 1'b0, 1'b0);
    run_block(0, 1'b0, 1'b0);

    push_block(1, 2, 1'b0, 1'b0);
    run_block(1, 1'b0, 1'b0);

    hold_v[0] = 1'b1;
    push_block(0, 3, 1'b0, 1'b0);
    run_block(0, 1'b0, 1'b0);
    hold_v[0] = 1'b0;

    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
